// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and helpers for the sync_fifo_wr_arbiter slice.
package sync_fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_MAX_REQ = 16;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/sync_fifo_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i, wrapping.
module sync_fifo_arb_rr_pick
    import sync_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = arb_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   onehot_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 any_o
);

    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap keeps non-power-of-two NUM_REQ in range.
            sum = {1'b0, ptr_i} + (IDX_WIDTH + 1)'(i);
            if (sum >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
            end
            cand = sum[IDX_WIDTH-1:0];
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port between NUM_REQ producers.
// Define SYNC_FIFO_ARB_PKT_LOCK_EN to hold the grant for a whole packet (req_last_h_i).
module sync_fifo_wr_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = arb_idx_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          reset_h_i,
    input  logic [NUM_REQ-1:0]            req_valid_h_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_h_i,
    output logic [NUM_REQ-1:0]            req_ready_h_o,
    output logic                          fifo_write_en_h_o,
    output logic [DATA_WIDTH-1:0]         fifo_write_data_o,
    input  logic                          fifo_full_h_i,
    output logic [IDX_WIDTH-1:0]          grant_idx_o,
    output logic                          locked_h_o
);

    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] pick_idx, win_idx;
    logic [NUM_REQ-1:0]   unused_pick_onehot;
    logic                 pick_any, win_valid, xfer;

    sync_fifo_arb_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req_i    (req_valid_h_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (unused_pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

`ifdef SYNC_FIFO_ARB_PKT_LOCK_EN
    arb_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;

    // A locked owner keeps the port even while its valid is low.
    always_comb begin
        win_valid = pick_any;
        win_idx   = pick_idx;
        if (state_q == ARB_LOCKED) begin
            win_valid = 1'b1;
            win_idx   = owner_q;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (xfer) begin
            if (state_q == ARB_IDLE && !req_last_h_i[win_idx]) begin
                state_d = ARB_LOCKED;
                owner_d = win_idx;
            end else if (state_q == ARB_LOCKED && req_last_h_i[win_idx]) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_h_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign locked_h_o = (state_q == ARB_LOCKED);
`else
    logic unused_last;

    assign win_valid   = pick_any;
    assign win_idx     = pick_idx;
    assign locked_h_o  = 1'b0;
    assign unused_last = ^req_last_h_i;
`endif

    always_comb begin
        req_ready_h_o     = '0;
        fifo_write_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!reset_h_i && win_valid && win_idx == IDX_WIDTH'(k)) begin
                req_ready_h_o[k]  = !fifo_full_h_i;
                fifo_write_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_write_en_h_o = |(req_valid_h_i & req_ready_h_o);
    assign xfer              = fifo_write_en_h_o;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        if (xfer) begin
            grant_idx_d = win_idx;
            rr_ptr_d    = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : win_idx + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_h_i) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_sync_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;
`ifdef SYNC_FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk, rst, full, we, locked;
    logic [N-1:0]    valid, last, ready;
    logic [N*DW-1:0] data;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   gidx;

    int n_cmp, n_fail;

    // Reference model state
    int            m_ptr, m_owner, m_grant;
    bit            m_locked;
    bit            exp_wv;
    int            exp_win;
    logic [N-1:0]  exp_ready;
    logic          exp_we;
    logic [DW-1:0] exp_data;

    // Producers: beats remaining in current packet, current beat data
    int            rem   [N];
    logic [DW-1:0] pdata [N];

    sync_fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i             (clk),
        .reset_h_i         (rst),
        .req_valid_h_i     (valid),
        .req_data_i        (data),
        .req_last_h_i      (last),
        .req_ready_h_o     (ready),
        .fifo_write_en_h_o (we),
        .fifo_write_data_o (wdata),
        .fifo_full_h_i     (full),
        .grant_idx_o       (gidx),
        .locked_h_o        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic apply_inputs();
        for (int k = 0; k < N; k++) begin
            valid[k]           = rem[k] > 0;
            last[k]            = rem[k] == 1;
            data[k*DW +: DW]   = pdata[k];
        end
    endtask

    task automatic model_eval();
        int c;
        exp_wv  = 1'b0;
        exp_win = 0;
        if (!rst) begin
            if (m_locked) begin
                exp_wv  = 1'b1;
                exp_win = m_owner;
            end else begin
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!exp_wv && valid[c]) begin
                        exp_wv  = 1'b1;
                        exp_win = c;
                    end
                end
            end
        end
        exp_ready = '0;
        if (exp_wv && !full) exp_ready[exp_win] = 1'b1;
        exp_we   = |(valid & exp_ready);
        exp_data = exp_wv ? data[exp_win*DW +: DW] : '0;
    endtask

    task automatic model_commit();
        if (rst) begin
            m_ptr    = 0;
            m_owner  = 0;
            m_grant  = 0;
            m_locked = 1'b0;
        end else if (exp_we) begin
            m_grant = exp_win;
            m_ptr   = (exp_win + 1) % N;
            if (LOCK) begin
                if (!m_locked && !last[exp_win]) begin
                    m_locked = 1'b1;
                    m_owner  = exp_win;
                end else if (m_locked && last[exp_win]) begin
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    task automatic pre_cycle();
        apply_inputs();
        #1;
        model_eval();
    endtask

    task automatic post_cycle();
        @(posedge clk);
        model_commit();
        if (!rst && exp_we) begin
            rem[exp_win]   = rem[exp_win] - 1;
            pdata[exp_win] = DW'($urandom);
        end
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        for (int k = 0; k < N; k++) rem[k] = 0;
        pre_cycle();
        post_cycle();
        rst = 1'b0;
    endtask

    task automatic refill(input int k, input int len);
        if (rem[k] == 0) begin
            rem[k]   = len;
            pdata[k] = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            valid = N'($urandom);
            last  = N'($urandom);
            data  = {$urandom, $urandom};
            full  = 1'(c == 1);
            #1;
            n_cmp++;
            if (ready !== '0 || we !== 1'b0 || wdata !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: ready=%b we=%b data=%h, required 0/0/0",
                         ready, we, wdata);
            end
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        valid = '0;
        full  = 1'b0;
        m_ptr = 0; m_owner = 0; m_grant = 0; m_locked = 1'b0;
        for (int k = 0; k < N; k++) begin
            rem[k]   = 0;
            pdata[k] = '0;
        end
        #1;
        n_cmp++;
        if (gidx !== '0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%0d locked=%b, required 0/0", gidx, locked);
        end
        n_cmp++;
        if (ready !== '0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL no_request: ready=%b we=%b, required 0000/0", ready, we);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] e;
        int           w;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) refill(k, 1);
            w = i % N;
            pre_cycle();
            e = '0;
            e[w] = 1'b1;
            n_cmp++;
            if (ready !== e || we !== 1'b1 || wdata !== pdata[w]) begin
                n_fail++;
                $display("FAIL rotation_beat%0d: ready=%b we=%b data=%h, required %b/1/%h",
                         i, ready, we, wdata, e, pdata[w]);
            end
            post_cycle();
            n_cmp++;
            if (gidx !== IW'(w)) begin
                n_fail++;
                $display("FAIL rotation_grant%0d: got %0d, required %0d", i, gidx, w);
            end
        end
    endtask

    task automatic test_skip();
        logic [N-1:0] e;
        int           w;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            refill(1, 1);
            refill(3, 1);
            w = (i % 2 == 0) ? 1 : 3;
            pre_cycle();
            e = '0;
            e[w] = 1'b1;
            n_cmp++;
            if (ready !== e || we !== 1'b1 || wdata !== pdata[w]) begin
                n_fail++;
                $display("FAIL skip_beat%0d: ready=%b we=%b data=%h, required %b/1/%h",
                         i, ready, we, wdata, e, pdata[w]);
            end
            post_cycle();
            n_cmp++;
            if (gidx !== IW'(w)) begin
                n_fail++;
                $display("FAIL skip_grant%0d: got %0d, required %0d", i, gidx, w);
            end
        end
    endtask

    task automatic test_packet();
        int           seq [5];
        bit           lk  [5];
        logic [N-1:0] e;
        if (LOCK) begin
            seq = '{2, 2, 2, 2, 0};
            lk  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            seq = '{2, 0, 2, 0, 2};
            lk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end
        do_reset();
        refill(1, 1);
        pre_cycle();
        post_cycle();
        n_cmp++;
        if (gidx !== IW'(1)) begin
            n_fail++;
            $display("FAIL packet_setup_grant: got %0d, required 1", gidx);
        end
        refill(2, 4);
        for (int j = 0; j < 5; j++) begin
            refill(0, 1);
            pre_cycle();
            e = '0;
            e[seq[j]] = 1'b1;
            n_cmp++;
            if (ready !== e || we !== 1'b1 || wdata !== pdata[seq[j]]) begin
                n_fail++;
                $display("FAIL packet_beat%0d: ready=%b we=%b data=%h, required %b/1/%h",
                         j, ready, we, wdata, e, pdata[seq[j]]);
            end
            post_cycle();
            n_cmp++;
            if (gidx !== IW'(seq[j]) || locked !== lk[j]) begin
                n_fail++;
                $display("FAIL packet_state%0d: grant=%0d locked=%b, required %0d/%b",
                         j, gidx, locked, seq[j], lk[j]);
            end
        end
    endtask

    task automatic test_full_stall();
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled    = 1'b0;
        do_reset();
        refill(2, 4);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) refill(0, 1);
            if (!stalled && rem[2] == 2) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            full = (stall_left > 0);
            pre_cycle();
            n_cmp++;
            if (ready !== exp_ready || we !== exp_we || wdata !== exp_data) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: ready=%b we=%b data=%h, required %b/%b/%h",
                         c, ready, we, wdata, exp_ready, exp_we, exp_data);
            end
            if (full) begin
                n_cmp++;
                if (ready !== '0 || we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_blocked%0d: ready=%b we=%b, required 0000/0",
                             c, ready, we);
                end
            end
            post_cycle();
            if (stall_left > 0) stall_left--;
            n_cmp++;
            if (gidx !== IW'(m_grant) || locked !== m_locked) begin
                n_fail++;
                $display("FAIL stall_state%0d: grant=%0d locked=%b, required %0d/%b",
                         c, gidx, locked, m_grant, m_locked);
            end
        end
        full = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        refill(2, 4);
        for (int c = 0; c < 2; c++) begin
            pre_cycle();
            post_cycle();
        end
        refill(0, 1);
        rst = 1'b1;
        pre_cycle();
        n_cmp++;
        if (ready !== '0 || we !== 1'b0 || wdata !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%b we=%b data=%h, required 0/0/0",
                     ready, we, wdata);
        end
        post_cycle();
        rst = 1'b0;
        n_cmp++;
        if (gidx !== '0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: grant=%0d locked=%b, required 0/0", gidx, locked);
        end
        pre_cycle();
        n_cmp++;
        if (ready !== 4'b0001 || wdata !== pdata[0]) begin
            n_fail++;
            $display("FAIL midreset_first: ready=%b data=%h, required 0001/%h",
                     ready, wdata, pdata[0]);
        end
        post_cycle();
        n_cmp++;
        if (gidx !== '0) begin
            n_fail++;
            $display("FAIL midreset_grant: got %0d, required 0", gidx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0 && $urandom_range(0, 3) == 0) begin
                    refill(k, int'($urandom_range(1, 4)));
                end
            end
            full = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 49) == 0);
            pre_cycle();
            n_cmp++;
            if (ready !== exp_ready || we !== exp_we || wdata !== exp_data) begin
                n_fail++;
                $display("FAIL random_cycle%0d: ready=%b we=%b data=%h, required %b/%b/%h",
                         c, ready, we, wdata, exp_ready, exp_we, exp_data);
            end
            post_cycle();
            n_cmp++;
            if (gidx !== IW'(m_grant) || locked !== m_locked) begin
                n_fail++;
                $display("FAIL random_state%0d: grant=%0d locked=%b, required %0d/%b",
                         c, gidx, locked, m_grant, m_locked);
            end
        end
        rst  = 1'b0;
        full = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        full   = 1'b0;
        valid  = '0;
        last   = '0;
        data   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_skip();
        test_packet();
        test_full_stall();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo_in` write port between `NUM_REQ` producers in the same clock domain. Each producer sees a valid/ready beat interface. The arbiter drives the FIFO's `fifo_write_en_h_i` / `fifo_write_data_i` and honours `fifo_full_h_o`. Optionally it keeps a grant locked for a whole multi-beat packet, so packets never interleave in the FIFO.

## Interface

Parameters:
- `NUM_REQ`, 4: number of producers; 2..16.
- `DATA_WIDTH`, 16: beat width; must equal the FIFO's `DATA_WIDTH`.
- `IDX_WIDTH`, `$clog2(NUM_REQ)`: requester index width; derived, not overridden.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `reset_h_i`  in  1  reset; synchronous, active-high.
- `req_valid_h_i`  in  NUM_REQ  per-producer beat valid.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH  beat data; producer k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_last_h_i`  in  NUM_REQ  marks the final beat of a packet; ignored unless the lock feature is compiled in.
- `req_ready_h_o`  out  NUM_REQ  per-producer accept; at most one bit high.
- `fifo_write_en_h_o`  out  1  to FIFO `fifo_write_en_h_i`.
- `fifo_write_data_o`  out  DATA_WIDTH  to FIFO `fifo_write_data_i`.
- `fifo_full_h_i`  in  1  from FIFO `fifo_full_h_o`.
- `grant_idx_o`  out  IDX_WIDTH  index of the current or last winner.
- `locked_h_o`  out  1  high while a packet owns the port.

## Operation

- Transfer condition: a beat from producer k transfers when `req_valid_h_i[k] && req_ready_h_o[k]`.
- Write strobe: `fifo_write_en_h_o = |(req_valid_h_i & req_ready_h_o)`.
- Write data: `fifo_write_data_o` = data of the granted producer; `'0` when no producer is granted.
- Ready rule: `req_ready_h_o[k]` is high only if k is the current winner and `fifo_full_h_i == 0`. Ready may depend on valid.
- Producer rule: a producer must hold valid, data and last stable until its transfer; the arbiter does not check this.
- Winner selection (IDLE): the first requester with valid high, searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
- Pointer update: on every transfer, `rr_ptr` becomes `(winner + 1) mod NUM_REQ`. At `winner == NUM_REQ-1` it wraps to 0.
- `rr_ptr` is registered, IDX_WIDTH bits wide. For a non-power-of-two NUM_REQ, the wrap uses an explicit compare.
- State machine (`SYNC_FIFO_ARB_PKT_LOCK_EN` defined):
  - IDLE to LOCKED: a transfer with `req_last_h_i[winner] == 0`. The winner is stored in `owner_q`.
  - LOCKED: the winner is `owner_q` regardless of other requests.
  - LOCKED to IDLE: a transfer with last high. `rr_ptr` advances at that transfer.
  - A single-beat packet (last high on the first beat) stays in IDLE.
- Full FIFO: no transfer occurs. State, `owner_q` and `rr_ptr` are all held, and no switch happens while the FIFO is full.
- Owner drops valid while LOCKED: the port stays locked and other producers wait. A packet is never truncated.
- No requester valid: no winner, all ready bits low, `grant_idx_o` holds its last value.
- `grant_idx_o`: registered. It updates on each transfer to that transfer's winner.
- `locked_h_o`: equals (state == LOCKED).

## Timing

- Latency: zero-cycle combinational path from `req_valid_h_i` / `fifo_full_h_i` to ready and write-enable. The FIFO write occurs at the same edge as the handshake.
- Full path: `fifo_full_h_i` is combinational from FIFO pointers, so the full-to-ready path is purely combinational. Integration must budget this path.
- Registered state: state, `owner_q`, `rr_ptr` and `grant_idx_o` update only at the rising edge following a transfer.
- Reset, while `reset_h_i` is high:
  - `req_ready_h_o = 0`, `fifo_write_en_h_o = 0`, `fifo_write_data_o = 0`, independent of the inputs.
  - At the next edge: state becomes IDLE, and `rr_ptr`, `owner_q` and `grant_idx_o` become 0.
- Reset mid-packet: the lock is discarded. The FIFO is not flushed by this block.
- Throughput: one beat per cycle while the FIFO is not full. Switching between producers costs no bubble cycles.

## Configuration

- Macro: `SYNC_FIFO_ARB_PKT_LOCK_EN`.
- Defined: the IDLE/LOCKED packet lock operates as above, and `req_last_h_i` is used.
- Undefined: the state register is absent and the block arbitrates per beat. Round-robin applies on every transfer, `locked_h_o` is tied to 0, and `req_last_h_i` is unused.

## Structure

- Package `sync_fifo_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_LOCKED};
  - constant `ARB_MAX_REQ = 16`;
  - function `arb_idx_width(n)`.
- Sub-module `sync_fifo_arb_rr_pick`: combinational rotate-priority picker.
  - Inputs: `req` vector, `ptr`.
  - Outputs: `onehot`, `idx`, `any`.
  - Instantiated once, in IDLE/per-beat selection.

## Test plan

- Basic rotation: NUM_REQ=4, all four valid continuously with single-beat packets, FIFO never full -> grants cycle 0,1,2,3,0; one write per cycle; no bubbles.
- Skipping idle requesters: only producers 1 and 3 valid, `rr_ptr` = 0 -> grants alternate 1,3,1,3; `fifo_write_data_o` matches the granted producer's data on every write.
- Packet lock (macro defined): producer 2 sends 4 beats with last on beat 4 while producer 0 is valid throughout -> four consecutive writes from 2, `locked_h_o` high for beats 1-3, then producer 0 granted.
- Full stall: `fifo_full_h_i` high for 3 cycles during a locked packet -> ready and write-enable 0 for those 3 cycles; owner and beat order unchanged; resumes on the cycle full drops.
- Mid-packet reset: `reset_h_i` pulsed after beat 2 of 4 -> outputs 0 during reset; afterwards IDLE, `rr_ptr` = 0, `grant_idx_o` = 0, and producer 0 wins first if valid.
- Macro undefined, same stimulus as the packet-lock scenario -> beats interleave 2,0,2,0; `locked_h_o` stays 0.
